// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types and constants for the two-master RAM arbiter.
//   master_id_t : master index (0 = CPU processor_port, 1 = aux boot loader / DMA)
//   rd_state_t  : read tracker states
//   N_MASTERS   : number of requesters
//   CNT_W       : read latency counter width (RD_LAT is 1..3)
package ram_arb_pkg;

    localparam int N_MASTERS = 2;
    localparam int CNT_W     = 2;

    typedef logic master_id_t;

    localparam master_id_t M_CPU = 1'b0;
    localparam master_id_t M_AUX = 1'b1;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_WAIT  = 2'd1,
        RD_READY = 2'd2
    } rd_state_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: one master's request/response bundle towards the arbiter.
//   addr, wr_data, wr_en, rd_en, rd_ack : master -> arbiter
//   busy, rd_data, rd_ready             : arbiter -> master
// modport master: the requester side; modport slave: the arbiter side.
interface ram_arbiter_if #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_en;
    logic              rd_en;
    logic              busy;
    logic [DATA_W-1:0] rd_data;
    logic              rd_ready;
    logic              rd_ack;

    modport master (
        output addr, wr_data, wr_en, rd_en, rd_ack,
        input  busy, rd_data, rd_ready
    );

    modport slave (
        input  addr, wr_data, wr_en, rd_en, rd_ack,
        output busy, rd_data, rd_ready
    );
endinterface

// File: rtl/ram_arb_rd_tracker.sv
// ram_arb_rd_tracker: per-master read tracker. Follows one outstanding read
// from acceptance to the master's acknowledge and holds the returned data.
//   clk, rst_n   : clock, synchronous active-low reset
//   start        : a read from this master was accepted this cycle
//   rd_ack       : master consumed the read data (honoured only in READY)
//   ram_rd_data  : shared RAM read bus
//   idle         : tracker can take a new read
//   rd_ready     : rd_data is valid
//   rd_data      : holding register for the returned word
module ram_arb_rd_tracker
    import ram_arb_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              rd_ack,
    input  logic [DATA_W-1:0] ram_rd_data,
    output logic              idle,
    output logic              rd_ready,
    output logic [DATA_W-1:0] rd_data
);

    localparam logic [1:0] ST_IDLE  = RD_IDLE;
    localparam logic [1:0] ST_WAIT  = RD_WAIT;
    localparam logic [1:0] ST_READY = RD_READY;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              ready_q, ready_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        ready_d = ready_q;
        case (state_q)
            ST_IDLE: begin
                // WAIT is entered in the ram_rd_en cycle, so the counter hits
                // zero exactly in the cycle the RAM drives valid data.
                if (start) begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_W'(RD_LAT);
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    data_d  = ram_rd_data;
                    ready_d = 1'b1;
                    state_d = ST_READY;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_READY: begin
                if (rd_ack) begin
                    ready_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            ready_q <= ready_d;
        end
    end

    // The ack cycle is still READY, so it keeps blocking a new read.
    assign idle     = (state_q == ST_IDLE);
    assign rd_ready = ready_q;
    assign rd_data  = data_q;

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: arbitrates the single on-chip RAM port between master 0 (CPU)
// and master 1 (UART boot loader / DMA). One access accepted per cycle; the
// winner sees busy=0 and its request appears registered on ram_* next cycle.
//   clk, rst_n          : clock, synchronous active-low reset
//   m0, m1              : master request/response bundles (slave modport)
//   ram_addr/ram_wr_data/ram_wr_en/ram_rd_en : registered RAM command
//   ram_rd_data         : RAM read data, valid RD_LAT cycles after ram_rd_en
// Build option: define RAM_ARB_FIXED_PRIO_EN for fixed priority (m0 always
// wins a tie, m1 may starve); default is round robin on ties.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    ram_arbiter_if.slave      m0,
    ram_arbiter_if.slave      m1,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wr_data,
    output logic              ram_wr_en,
    output logic              ram_rd_en,
    input  logic [DATA_W-1:0] ram_rd_data
);

    logic [N_MASTERS-1:0][ADDR_W-1:0] addr_v;
    logic [N_MASTERS-1:0][DATA_W-1:0] wdata_v;
    logic [N_MASTERS-1:0][DATA_W-1:0] rd_data_v;
    logic [N_MASTERS-1:0]             wr_en_v, rd_en_v, rd_ack_v;
    logic [N_MASTERS-1:0]             trk_idle, trk_start, rd_ready_v;
    logic [N_MASTERS-1:0]             elig, gnt, busy_v;
    logic                             grant_vld;
    master_id_t                       winner;

    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wr_data_q, ram_wr_data_d;
    logic              ram_wr_en_q, ram_wr_en_d;
    logic              ram_rd_en_q, ram_rd_en_d;

    assign addr_v   = {m1.addr, m0.addr};
    assign wdata_v  = {m1.wr_data, m0.wr_data};
    assign wr_en_v  = {m1.wr_en, m0.wr_en};
    assign rd_en_v  = {m1.rd_en, m0.rd_en};
    assign rd_ack_v = {m1.rd_ack, m0.rd_ack};

`ifndef RAM_ARB_FIXED_PRIO_EN
    master_id_t last_grant_q, last_grant_d;
`endif

    always_comb begin
        // A write is always eligible (write wins over a simultaneous read);
        // a pure read needs an idle tracker.
        for (int i = 0; i < N_MASTERS; i++) begin
            elig[i] = wr_en_v[i] | (rd_en_v[i] & trk_idle[i]);
        end
        grant_vld = |elig;
        if (&elig) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
            winner = M_CPU;
`else
            winner = ~last_grant_q;
`endif
        end else begin
            winner = elig[1] ? M_AUX : M_CPU;
        end

        gnt[0] = grant_vld & (winner == M_CPU);
        gnt[1] = grant_vld & (winner == M_AUX);
        for (int i = 0; i < N_MASTERS; i++) begin
            busy_v[i]    = ~rst_n | ~gnt[i];
            trk_start[i] = gnt[i] & rd_en_v[i] & ~wr_en_v[i];
        end

        ram_wr_en_d   = grant_vld & wr_en_v[winner];
        ram_rd_en_d   = grant_vld & rd_en_v[winner] & ~wr_en_v[winner];
        ram_addr_d    = grant_vld ? addr_v[winner]  : ram_addr_q;
        ram_wr_data_d = grant_vld ? wdata_v[winner] : ram_wr_data_q;
`ifndef RAM_ARB_FIXED_PRIO_EN
        last_grant_d  = grant_vld ? winner : last_grant_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ram_addr_q    <= '0;
            ram_wr_data_q <= '0;
            ram_wr_en_q   <= 1'b0;
            ram_rd_en_q   <= 1'b0;
`ifndef RAM_ARB_FIXED_PRIO_EN
            last_grant_q  <= M_AUX;   // m0 wins the first tie
`endif
        end else begin
            ram_addr_q    <= ram_addr_d;
            ram_wr_data_q <= ram_wr_data_d;
            ram_wr_en_q   <= ram_wr_en_d;
            ram_rd_en_q   <= ram_rd_en_d;
`ifndef RAM_ARB_FIXED_PRIO_EN
            last_grant_q  <= last_grant_d;
`endif
        end
    end

    for (genvar i = 0; i < N_MASTERS; i++) begin : g_trk
        ram_arb_rd_tracker #(
            .DATA_W (DATA_W),
            .RD_LAT (RD_LAT)
        ) u_trk (
            .clk         (clk),
            .rst_n       (rst_n),
            .start       (trk_start[i]),
            .rd_ack      (rd_ack_v[i]),
            .ram_rd_data (ram_rd_data),
            .idle        (trk_idle[i]),
            .rd_ready    (rd_ready_v[i]),
            .rd_data     (rd_data_v[i])
        );
    end

    assign m0.busy     = busy_v[0];
    assign m0.rd_ready = rd_ready_v[0];
    assign m0.rd_data  = rd_data_v[0];
    assign m1.busy     = busy_v[1];
    assign m1.rd_ready = rd_ready_v[1];
    assign m1.rd_data  = rd_data_v[1];

    assign ram_addr    = ram_addr_q;
    assign ram_wr_data = ram_wr_data_q;
    assign ram_wr_en   = ram_wr_en_q;
    assign ram_rd_en   = ram_rd_en_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed scenarios plus a randomized run against a
// transaction-level model of the arbiter (shadow memory, per-master
// outstanding read with its due cycle, round-robin / fixed-priority tie rule).
module tb_ram_arbiter;

    localparam int ADDR_W = 24;
    localparam int DATA_W = 16;
    localparam int RD_LAT = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m0_if ();
    ram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m1_if ();

    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wr_data;
    logic              ram_wr_en;
    logic              ram_rd_en;
    logic [DATA_W-1:0] ram_rd_data;

    ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .m0          (m0_if),
        .m1          (m1_if),
        .ram_addr    (ram_addr),
        .ram_wr_data (ram_wr_data),
        .ram_wr_en   (ram_wr_en),
        .ram_rd_en   (ram_rd_en),
        .ram_rd_data (ram_rd_data)
    );

    // Behavioural RAM with RD_LAT-cycle read latency.
    logic [DATA_W-1:0] ram_mem [256] = '{default: '0};
    logic [DATA_W-1:0] rd_pipe [RD_LAT] = '{default: '0};
    always @(posedge clk) begin
        if (ram_wr_en) ram_mem[ram_addr[7:0]] <= ram_wr_data;
        rd_pipe[0] <= ram_rd_en ? ram_mem[ram_addr[7:0]] : 16'hDEAD;
        for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign ram_rd_data = rd_pipe[RD_LAT-1];

    int n_chk  = 0;
    int n_pass = 0;
    logic exp_last;                     // model of the last granted master
    logic [DATA_W-1:0] shadow [256];    // model of RAM contents

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req();
        m0_if.wr_en = 0; m0_if.rd_en = 0; m0_if.rd_ack = 0;
        m1_if.wr_en = 0; m1_if.rd_en = 0; m1_if.rd_ack = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        m0_if.wr_en = 1; m0_if.addr = 24'h1; m0_if.wr_data = 16'h1111;
        m1_if.wr_en = 1; m1_if.addr = 24'h2; m1_if.wr_data = 16'h2222;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_chk++; if (ram_wr_en !== 1'b0) $display("FAIL rst_wr_en got=%b exp=0", ram_wr_en); else n_pass++;
            n_chk++; if (ram_rd_en !== 1'b0) $display("FAIL rst_rd_en got=%b exp=0", ram_rd_en); else n_pass++;
            n_chk++; if (ram_addr !== 24'h0) $display("FAIL rst_addr got=%h exp=0", ram_addr); else n_pass++;
            n_chk++; if (m0_if.busy !== 1'b1) $display("FAIL rst_m0_busy got=%b exp=1", m0_if.busy); else n_pass++;
            n_chk++; if (m1_if.busy !== 1'b1) $display("FAIL rst_m1_busy got=%b exp=1", m1_if.busy); else n_pass++;
            n_chk++; if ({m1_if.rd_ready, m0_if.rd_ready} !== 2'b00) $display("FAIL rst_rd_ready got=%b exp=00", {m1_if.rd_ready, m0_if.rd_ready}); else n_pass++;
            n_chk++; if (m0_if.rd_data !== 16'h0) $display("FAIL rst_m0_rd_data got=%h exp=0", m0_if.rd_data); else n_pass++;
            tick();
        end
        rst_n = 1;
        @(negedge clk);
        n_chk++; if (m0_if.busy !== 1'b0) $display("FAIL first_tie_m0_busy got=%b exp=0", m0_if.busy); else n_pass++;
        n_chk++; if (m1_if.busy !== 1'b1) $display("FAIL first_tie_m1_busy got=%b exp=1", m1_if.busy); else n_pass++;
        exp_last = 1'b0; shadow[8'h01] = 16'h1111;
        tick(); clear_req();
        @(negedge clk);
        n_chk++; if (ram_wr_en !== 1'b1 || ram_addr !== 24'h1 || ram_wr_data !== 16'h1111)
            $display("FAIL first_tie_ram got=%b/%h/%h exp=1/000001/1111", ram_wr_en, ram_addr, ram_wr_data); else n_pass++;
        tick();
    endtask

    task automatic test_single_write();
        m0_if.wr_en = 1; m0_if.addr = 24'h10; m0_if.wr_data = 16'hBEEF;
        @(negedge clk);
        n_chk++; if (m0_if.busy !== 1'b0) $display("FAIL wr_busy got=%b exp=0", m0_if.busy); else n_pass++;
        exp_last = 1'b0; shadow[8'h10] = 16'hBEEF;
        tick(); clear_req();
        @(negedge clk);
        n_chk++; if (ram_wr_en !== 1'b1) $display("FAIL wr_strobe got=%b exp=1", ram_wr_en); else n_pass++;
        n_chk++; if (ram_rd_en !== 1'b0) $display("FAIL wr_no_rd got=%b exp=0", ram_rd_en); else n_pass++;
        n_chk++; if (ram_addr !== 24'h10) $display("FAIL wr_addr got=%h exp=000010", ram_addr); else n_pass++;
        n_chk++; if (ram_wr_data !== 16'hBEEF) $display("FAIL wr_data got=%h exp=beef", ram_wr_data); else n_pass++;
        tick();
        @(negedge clk);
        n_chk++; if (ram_wr_en !== 1'b0) $display("FAIL wr_pulse got=%b exp=0", ram_wr_en); else n_pass++;
    endtask

    task automatic test_read_latency();
        tick();
        m1_if.rd_en = 1; m1_if.addr = 24'h10;
        @(negedge clk);
        n_chk++; if (m1_if.busy !== 1'b0) $display("FAIL lat_busy got=%b exp=0", m1_if.busy); else n_pass++;
        exp_last = 1'b1;
        tick(); clear_req();
        @(negedge clk);
        n_chk++; if (ram_rd_en !== 1'b1 || ram_addr !== 24'h10) $display("FAIL lat_ram_rd got=%b/%h exp=1/000010", ram_rd_en, ram_addr); else n_pass++;
        n_chk++; if (m1_if.rd_ready !== 1'b0) $display("FAIL lat_early_ready got=%b exp=0", m1_if.rd_ready); else n_pass++;
        for (int k = 0; k < RD_LAT; k++) begin
            tick();
            @(negedge clk);
            n_chk++; if (m1_if.rd_ready !== 1'b0) $display("FAIL lat_wait_ready got=%b exp=0", m1_if.rd_ready); else n_pass++;
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            @(negedge clk);
            n_chk++; if (m1_if.rd_ready !== 1'b1) $display("FAIL lat_ready got=%b exp=1", m1_if.rd_ready); else n_pass++;
            n_chk++; if (m1_if.rd_data !== 16'hBEEF) $display("FAIL lat_data got=%h exp=beef", m1_if.rd_data); else n_pass++;
            n_chk++; if (m0_if.rd_ready !== 1'b0) $display("FAIL lat_m0_ready got=%b exp=0", m0_if.rd_ready); else n_pass++;
        end
        tick(); m1_if.rd_ack = 1;
        @(negedge clk);
        n_chk++; if (m1_if.rd_ready !== 1'b1) $display("FAIL lat_ack_cycle got=%b exp=1", m1_if.rd_ready); else n_pass++;
        tick(); m1_if.rd_ack = 0;
        @(negedge clk);
        n_chk++; if (m1_if.rd_ready !== 1'b0) $display("FAIL lat_after_ack got=%b exp=0", m1_if.rd_ready); else n_pass++;
    endtask

    task automatic test_contention();
        logic w, prev_w;
        tick();
        m0_if.wr_en = 1; m0_if.addr = 24'h20; m0_if.wr_data = 16'hA0A0;
        m1_if.wr_en = 1; m1_if.addr = 24'h30; m1_if.wr_data = 16'hB1B1;
        prev_w = 1'b0;
        for (int c = 0; c < 8; c++) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
            w = 1'b0;
`else
            w = ~exp_last;
`endif
            @(negedge clk);
            n_chk++; if (m0_if.busy !== w) $display("FAIL cont_m0_busy c=%0d got=%b exp=%b", c, m0_if.busy, w); else n_pass++;
            n_chk++; if (m1_if.busy !== ~w) $display("FAIL cont_m1_busy c=%0d got=%b exp=%b", c, m1_if.busy, ~w); else n_pass++;
            if (c > 0) begin
                n_chk++; if (ram_wr_en !== 1'b1 || ram_addr !== (prev_w ? 24'h30 : 24'h20))
                    $display("FAIL cont_ram c=%0d got=%b/%h exp=1/%h", c, ram_wr_en, ram_addr, prev_w ? 24'h30 : 24'h20); else n_pass++;
            end
            prev_w = w; exp_last = w;
            if (w) shadow[8'h30] = 16'hB1B1; else shadow[8'h20] = 16'hA0A0;
            tick();
        end
        clear_req();
        @(negedge clk);
        n_chk++; if (ram_addr !== (prev_w ? 24'h30 : 24'h20)) $display("FAIL cont_last got=%h", ram_addr); else n_pass++;
    endtask

    task automatic test_read_block();
        logic [DATA_W-1:0] d40;
        d40 = DATA_W'($urandom);
        tick();
        m0_if.rd_en = 1; m0_if.addr = 24'h10;
        @(negedge clk);
        n_chk++; if (m0_if.busy !== 1'b0) $display("FAIL blk_rd1_busy got=%b exp=0", m0_if.busy); else n_pass++;
        exp_last = 1'b0;
        tick();
        m0_if.rd_en = 0; m0_if.wr_en = 1; m0_if.addr = 24'h40; m0_if.wr_data = d40;
        @(negedge clk);
        n_chk++; if (m0_if.busy !== 1'b0) $display("FAIL blk_wr_busy got=%b exp=0", m0_if.busy); else n_pass++;
        shadow[8'h40] = d40;
        tick();
        m0_if.wr_en = 0; m0_if.rd_en = 1; m0_if.addr = 24'h40;
        for (int k = 0; k < RD_LAT + 5; k++) begin
            @(negedge clk);
            if (k == 0) begin
                n_chk++; if (ram_wr_en !== 1'b1 || ram_wr_data !== d40) $display("FAIL blk_wr_ram got=%b/%h exp=1/%h", ram_wr_en, ram_wr_data, d40); else n_pass++;
            end
            n_chk++; if (m0_if.busy !== 1'b1) $display("FAIL blk_busy k=%0d got=%b exp=1", k, m0_if.busy); else n_pass++;
            n_chk++; if (m0_if.rd_ready !== (k >= RD_LAT)) $display("FAIL blk_ready k=%0d got=%b exp=%b", k, m0_if.rd_ready, k >= RD_LAT); else n_pass++;
            if (k >= RD_LAT) begin
                n_chk++; if (m0_if.rd_data !== 16'hBEEF) $display("FAIL blk_data got=%h exp=beef", m0_if.rd_data); else n_pass++;
            end
            tick();
        end
        m0_if.rd_ack = 1;
        @(negedge clk);
        n_chk++; if (m0_if.busy !== 1'b1) $display("FAIL blk_ack_busy got=%b exp=1", m0_if.busy); else n_pass++;
        tick(); m0_if.rd_ack = 0;
        @(negedge clk);
        n_chk++; if (m0_if.busy !== 1'b0) $display("FAIL blk_rd2_busy got=%b exp=0", m0_if.busy); else n_pass++;
        n_chk++; if (m0_if.rd_ready !== 1'b0) $display("FAIL blk_ready_clr got=%b exp=0", m0_if.rd_ready); else n_pass++;
        tick(); clear_req();
        @(negedge clk);
        n_chk++; if (ram_rd_en !== 1'b1 || ram_addr !== 24'h40) $display("FAIL blk_rd2_ram got=%b/%h exp=1/000040", ram_rd_en, ram_addr); else n_pass++;
        for (int k = 0; k < RD_LAT; k++) tick();
        tick();
        @(negedge clk);
        n_chk++; if (m0_if.rd_ready !== 1'b1 || m0_if.rd_data !== shadow[8'h40])
            $display("FAIL blk_rd2_data got=%b/%h exp=1/%h", m0_if.rd_ready, m0_if.rd_data, shadow[8'h40]); else n_pass++;
        tick(); m0_if.rd_ack = 1;
        tick(); m0_if.rd_ack = 0;
    endtask

    task automatic test_reset_mid_read();
        tick();
        m1_if.rd_en = 1; m1_if.addr = 24'h20;
        @(negedge clk);
        n_chk++; if (m1_if.busy !== 1'b0) $display("FAIL mid_busy got=%b exp=0", m1_if.busy); else n_pass++;
        tick(); clear_req(); rst_n = 0;
        @(negedge clk);
        n_chk++; if (m1_if.busy !== 1'b1) $display("FAIL mid_rst_busy got=%b exp=1", m1_if.busy); else n_pass++;
        tick(); rst_n = 1; exp_last = 1'b1;
        @(negedge clk);
        n_chk++; if (ram_rd_en !== 1'b0 || ram_wr_en !== 1'b0) $display("FAIL mid_strobe got=%b%b exp=00", ram_rd_en, ram_wr_en); else n_pass++;
        for (int k = 0; k < RD_LAT + 3; k++) begin
            n_chk++; if (m1_if.rd_ready !== 1'b0) $display("FAIL mid_ready k=%0d got=%b exp=0", k, m1_if.rd_ready); else n_pass++;
            tick();
            @(negedge clk);
        end
        tick();
        m1_if.rd_en = 1; m1_if.addr = 24'h20;
        @(negedge clk);
        n_chk++; if (m1_if.busy !== 1'b0) $display("FAIL mid_idle_busy got=%b exp=0", m1_if.busy); else n_pass++;
        exp_last = 1'b1;
        tick(); clear_req();
        for (int k = 0; k < RD_LAT; k++) tick();
        tick();
        @(negedge clk);
        n_chk++; if (m1_if.rd_ready !== 1'b1 || m1_if.rd_data !== shadow[8'h20])
            $display("FAIL mid_rd_data got=%b/%h exp=1/%h", m1_if.rd_ready, m1_if.rd_data, shadow[8'h20]); else n_pass++;
        tick(); m1_if.rd_ack = 1;
        tick(); m1_if.rd_ack = 0;
    endtask

    task automatic test_random();
        logic [1:0] pend, wr, rd, ack, outst, elig, rdy;
        logic [1:0][ADDR_W-1:0] ad;
        logic [1:0][DATA_W-1:0] wd, exp_rd;
        int rdy_cyc [2];
        logic w, any, e_wr, e_rd;
        logic [ADDR_W-1:0] e_addr;
        logic [DATA_W-1:0] e_data;
        int op;
        tick(); clear_req(); rst_n = 0;
        tick(); rst_n = 1;
        exp_last = 1'b1;
        pend = '0; outst = '0; wr = '0; rd = '0; ad = '0; wd = '0; exp_rd = '0;
        rdy_cyc[0] = 0; rdy_cyc[1] = 0;
        e_wr = 0; e_rd = 0; e_addr = '0; e_data = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && $urandom_range(0, 2) != 0) begin
                    op = $urandom_range(0, 3);
                    pend[i] = 1'b1;
                    wr[i] = (op == 0) || (op == 3);
                    rd[i] = (op != 0);
                    ad[i] = ADDR_W'($urandom_range(0, 15) << 4);
                    wd[i] = DATA_W'($urandom);
                end
                ack[i] = ($urandom_range(0, 3) == 0);
            end
            m0_if.wr_en = pend[0] & wr[0]; m0_if.rd_en = pend[0] & rd[0];
            m0_if.addr = ad[0]; m0_if.wr_data = wd[0]; m0_if.rd_ack = ack[0];
            m1_if.wr_en = pend[1] & wr[1]; m1_if.rd_en = pend[1] & rd[1];
            m1_if.addr = ad[1]; m1_if.wr_data = wd[1]; m1_if.rd_ack = ack[1];
            for (int i = 0; i < 2; i++) begin
                elig[i] = pend[i] & (wr[i] | (rd[i] & ~outst[i]));
                rdy[i]  = outst[i] && (c >= rdy_cyc[i]);
            end
            any = |elig;
            if (&elig) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
                w = 1'b0;
`else
                w = ~exp_last;
`endif
            end else begin
                w = elig[1];
            end
            @(negedge clk);
            n_chk++; if (m0_if.busy !== ~(any & ~w)) $display("FAIL rnd_m0_busy c=%0d got=%b exp=%b", c, m0_if.busy, ~(any & ~w)); else n_pass++;
            n_chk++; if (m1_if.busy !== ~(any & w)) $display("FAIL rnd_m1_busy c=%0d got=%b exp=%b", c, m1_if.busy, ~(any & w)); else n_pass++;
            n_chk++; if ({m1_if.rd_ready, m0_if.rd_ready} !== rdy) $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, {m1_if.rd_ready, m0_if.rd_ready}, rdy); else n_pass++;
            if (rdy[0]) begin
                n_chk++; if (m0_if.rd_data !== exp_rd[0]) $display("FAIL rnd_m0_data c=%0d got=%h exp=%h", c, m0_if.rd_data, exp_rd[0]); else n_pass++;
            end
            if (rdy[1]) begin
                n_chk++; if (m1_if.rd_data !== exp_rd[1]) $display("FAIL rnd_m1_data c=%0d got=%h exp=%h", c, m1_if.rd_data, exp_rd[1]); else n_pass++;
            end
            n_chk++; if ({ram_wr_en, ram_rd_en} !== {e_wr, e_rd}) $display("FAIL rnd_strobe c=%0d got=%b%b exp=%b%b", c, ram_wr_en, ram_rd_en, e_wr, e_rd); else n_pass++;
            if (e_wr || e_rd) begin
                n_chk++; if (ram_addr !== e_addr) $display("FAIL rnd_addr c=%0d got=%h exp=%h", c, ram_addr, e_addr); else n_pass++;
            end
            if (e_wr) begin
                n_chk++; if (ram_wr_data !== e_data) $display("FAIL rnd_wdata c=%0d got=%h exp=%h", c, ram_wr_data, e_data); else n_pass++;
            end
            // Model update at the closing edge.
            for (int i = 0; i < 2; i++) if (ack[i] && rdy[i]) outst[i] = 1'b0;
            e_wr = any & wr[w];
            e_rd = any & rd[w] & ~wr[w];
            e_addr = ad[w];
            e_data = wd[w];
            if (any) begin
                if (wr[w]) begin
                    shadow[ad[w][7:0]] = wd[w];
                end else begin
                    outst[w] = 1'b1;
                    rdy_cyc[w] = c + RD_LAT + 2;
                    exp_rd[w] = shadow[ad[w][7:0]];
                end
                exp_last = w;
                pend[w] = 1'b0;
            end
            tick();
        end
        clear_req();
    endtask

    initial begin
        for (int a = 0; a < 256; a++) shadow[a] = '0;
        exp_last = 1'b1;
        clear_req();
        m0_if.addr = '0; m0_if.wr_data = '0;
        m1_if.addr = '0; m1_if.wr_data = '0;
        test_reset();
        test_single_write();
        test_read_latency();
        test_contention();
        test_read_block();
        test_reset_mid_read();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
